// File: rtl/cs_window_avg_if.sv
// Sample-stream bus for cs_window_avg: valid/ready sample input, flush, and the result outputs.
// The parameters must match those of the attached cs_window_avg instance.
interface cs_window_avg_if #(
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3
);
    localparam int SW = DW + $clog2(N);
    localparam int YW = SW + 1 - SHIFT;

    logic [DW-1:0] X;
    logic          x_valid;
    logic          x_ready;
    logic          flush;
    logic [YW-1:0] Y;
    logic          y_valid;
    logic          busy;

    modport master (
        output X, x_valid, flush,
        input  x_ready, Y, y_valid, busy
    );

    modport slave (
        input  X, x_valid, flush,
        output x_ready, Y, y_valid, busy
    );
endinterface

// File: rtl/cs_window_avg.sv
// Sliding-window approximate average: Y = (sum + N*Xappr) >> SHIFT, where Xappr is the largest
// window entry not above floor(sum/N). Uses a bit-serial restoring divider and a serial scan.
module cs_window_avg #(
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3
) (
    input  logic           clk,
    input  logic           reset,
    cs_window_avg_if.slave bus
);
    localparam int SW = DW + $clog2(N);
    localparam int YW = SW + 1 - SHIFT;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(SW + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SW - 1);
    localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_SCAN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [IW-1:0] wp_q, wp_d;
    logic [SW-1:0] quo_q, quo_d;
    logic [SW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] xappr_q, xappr_d;
    logic [YW-1:0] y_q, y_d;
    logic          y_valid_q, y_valid_d;

    logic [N-1:0][DW-1:0] win_vec;
    logic [DW-1:0] old_sample, cur_sample, xappr_new;
    logic [SW-1:0] sum_new;
    logic [SW:0]   trial, trial_sub, y_full, y_shift;
    logic          accept, do_flush, ge, hit, div_last, scan_last;

    assign do_flush   = (state_q == S_IDLE) && bus.flush;
    assign accept     = (state_q == S_IDLE) && !bus.flush && bus.x_valid;
    assign old_sample = win_vec[wp_q];
    assign cur_sample = win_vec[idx_q];
    assign sum_new    = sum_q - SW'(old_sample) + SW'(bus.X);
    assign div_last   = (cnt_q == LAST_CNT);
    assign scan_last  = (idx_q == LAST_IDX);

    // Window entries: cleared by flush, written only at the write pointer on an accepted sample.
    for (genvar gi = 0; gi < N; gi++) begin : g_win
        logic [DW-1:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if (do_flush) begin
                entry_d = '0;
            end else if (accept && (wp_q == IW'(gi))) begin
                entry_d = bus.X;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign win_vec[gi] = entry_q;
    end

    // Restoring division step: dividend shifts out of quo_q MSB-first, quotient bits shift in.
    assign trial     = {rem_q, quo_q[SW-1]};
    assign ge        = (trial >= N_EXT);
    assign trial_sub = trial - N_EXT;

    assign hit       = (SW'(cur_sample) <= quo_q) && (cur_sample > xappr_q);
    assign xappr_new = hit ? cur_sample : xappr_q;
    assign y_full    = {1'b0, sum_q} + N_EXT * (SW + 1)'(xappr_new);
    assign y_shift   = y_full >> SHIFT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_DIV;
            S_DIV:   if (div_last)  state_d = S_SCAN;
            S_SCAN:  if (scan_last) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.x_ready = (state_q == S_IDLE);
        bus.busy    = (state_q == S_DIV) || (state_q == S_SCAN);
        bus.Y       = y_q;
        bus.y_valid = y_valid_q;
    end

    always_comb begin
        sum_d     = sum_q;
        wp_d      = wp_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        xappr_d   = xappr_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (do_flush) begin
                    sum_d = '0;
                    wp_d  = '0;
                end else if (accept) begin
                    sum_d = sum_new;
                    wp_d  = (wp_q == LAST_IDX) ? '0 : wp_q + 1'b1;
                    quo_d = sum_new;
                    rem_d = '0;
                    cnt_d = '0;
                end
            end
            S_DIV: begin
                quo_d = {quo_q[SW-2:0], ge};
                rem_d = ge ? trial_sub[SW-1:0] : trial[SW-1:0];
                cnt_d = cnt_q + 1'b1;
                if (div_last) begin
                    idx_d   = '0;
                    xappr_d = '0;
                end
            end
            S_SCAN: begin
                xappr_d = xappr_new;
                idx_d   = idx_q + 1'b1;
                if (scan_last) begin
                    y_d       = YW'(y_shift);
                    y_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q     <= '0;
            wp_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            xappr_q   <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            wp_q      <= wp_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            xappr_q   <= xappr_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end
endmodule

// File: tb/tb_cs_window_avg.sv
// Directed bench for cs_window_avg: default instance (8/9/3) driven from a vector table plus
// handshake, flush and mid-scan reset sequences; a small 4/4/2 instance checks the parametrisation.
module tb_cs_window_avg;
    logic clk;
    logic rst0, rst1;
    int   checks = 0;
    int   errors = 0;

    cs_window_avg_if #(.DW(8), .N(9), .SHIFT(3)) b0 ();
    cs_window_avg_if #(.DW(4), .N(4), .SHIFT(2)) b1 ();

    cs_window_avg #(.DW(8), .N(9), .SHIFT(3)) u0 (.clk(clk), .reset(rst0), .bus(b0));
    cs_window_avg #(.DW(4), .N(4), .SHIFT(2)) u1 (.clk(clk), .reset(rst1), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit fl;
        int x;
        int y;
    } vec_t;

    vec_t vt[$];
    int   m_win[9];
    int   m_wp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int yv(input int sel);
        return (sel == 0) ? int'(b0.y_valid) : int'(b1.y_valid);
    endfunction

    function automatic int xr(input int sel);
        return (sel == 0) ? int'(b0.x_ready) : int'(b1.x_ready);
    endfunction

    function automatic int yo(input int sel);
        return (sel == 0) ? int'(b0.Y) : int'(b1.Y);
    endfunction

    function automatic int ref_y();
        int s = 0;
        int a;
        int xa = 0;
        for (int i = 0; i < 9; i++) s += m_win[i];
        a = s / 9;
        for (int i = 0; i < 9; i++)
            if (m_win[i] <= a && m_win[i] > xa) xa = m_win[i];
        return (s + 9 * xa) >> 3;
    endfunction

    task automatic drive(input int sel, input int x, input bit v, input bit f);
        if (sel == 0) begin
            b0.X = x[7:0]; b0.x_valid = v; b0.flush = f;
        end else begin
            b1.X = x[3:0]; b1.x_valid = v; b1.flush = f;
        end
    endtask

    // One accepted sample: checks ready, latency, x_ready low while busy, and the result.
    task automatic send(input int sel, input int x, input int exp_y, input int exp_lat,
                        input string name);
        int n = 0;
        int rdy = 0;
        @(negedge clk);
        chk({name, "_ready_in"}, xr(sel), 1);
        drive(sel, x, 1'b1, 1'b0);
        @(negedge clk);
        drive(sel, x, 1'b0, 1'b0);
        while (yv(sel) == 0 && n < 100) begin
            if (xr(sel) != 0) rdy++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk({name, "_timeout"}, n, exp_lat);
        end else begin
            chk({name, "_lat"}, n, exp_lat);
            chk({name, "_y"}, yo(sel), exp_y);
            chk({name, "_ready_low"}, rdy, 0);
            chk({name, "_ready_out"}, xr(sel), 1);
        end
        $display("txn %s dut%0d X=%0d Y=%0d lat=%0d", name, sel, x, yo(sel), n);
    endtask

    task automatic do_flush(input int x, input int prev_y, input string name);
        int pulses = 0;
        @(negedge clk);
        drive(0, x, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, x, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            if (b0.y_valid) pulses++;
            @(negedge clk);
        end
        chk({name, "_no_yvalid"}, pulses, 0);
        chk({name, "_y_hold"}, int'(b0.Y), prev_y);
        chk({name, "_idle"}, int'(b0.busy), 0);
        $display("txn %s dut0 flush X=%0d Y=%0d", name, x, b0.Y);
    endtask

    initial begin
        int prev_y;
        int exp_q[$];
        int acc, pulses, last_y, e, cnt;

        rst0 = 1'b0; rst1 = 1'b0;
        drive(0, 0, 1'b0, 1'b0);
        drive(1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_y0", int'(b0.Y), 0);
        chk("rst_yv0", int'(b0.y_valid), 0);
        chk("rst_busy0", int'(b0.busy), 0);
        chk("rst_y1", int'(b1.Y), 0);
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        chk("rst_ready0", int'(b0.x_ready), 1);
        chk("rst_ready1", int'(b1.x_ready), 1);

        vt.push_back('{0, 100, 12});
        vt.push_back('{0, 10, 25});
        vt.push_back('{0, 20, 27});
        vt.push_back('{0, 30, 31});
        vt.push_back('{0, 40, 47});
        vt.push_back('{0, 50, 53});
        vt.push_back('{0, 60, 72});
        vt.push_back('{0, 70, 92});
        vt.push_back('{0, 80, 113});
        vt.push_back('{0, 90, 112});
        vt.push_back('{0, 100, 135});
        vt.push_back('{1, 77, 135});
        vt.push_back('{0, 90, 11});
        vt.push_back('{1, 0, 11});
        vt.push_back('{0, 255, 31});
        vt.push_back('{0, 255, 63});
        vt.push_back('{0, 255, 95});
        vt.push_back('{0, 255, 127});
        vt.push_back('{0, 255, 159});
        vt.push_back('{0, 255, 191});
        vt.push_back('{0, 255, 223});
        vt.push_back('{0, 255, 255});
        vt.push_back('{0, 255, 573});

        prev_y = 0;
        foreach (vt[i]) begin
            if (vt[i].fl) begin
                do_flush(vt[i].x, prev_y, $sformatf("vec%0d_flush", i));
            end else begin
                send(0, vt[i].x, vt[i].y, 21, $sformatf("vec%0d", i));
            end
            prev_y = vt[i].y;
        end

        // Handshake: x_valid held high with X changing every cycle.
        do_flush(0, 573, "hs_pre_flush");
        for (int i = 0; i < 9; i++) m_win[i] = 0;
        m_wp = 0;
        acc = 0; pulses = 0; last_y = 573;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (b0.y_valid) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("hs_y", int'(b0.Y), e);
                    $display("txn hs_result dut0 Y=%0d", b0.Y);
                    last_y = e;
                end else begin
                    chk("hs_spurious_yvalid", 1, 0);
                end
            end else begin
                chk("hs_y_stable", int'(b0.Y), last_y);
            end
            if (c < 70) begin
                drive(0, (c * 37 + 5) & 255, 1'b1, 1'b0);
                if (b0.x_ready) begin
                    m_win[m_wp] = (c * 37 + 5) & 255;
                    m_wp = (m_wp == 8) ? 0 : m_wp + 1;
                    exp_q.push_back(ref_y());
                    acc++;
                    $display("txn hs_accept dut0 X=%0d", (c * 37 + 5) & 255);
                end
            end else begin
                drive(0, 0, 1'b0, 1'b0);
            end
        end
        chk("hs_pulse_count", pulses, acc);
        chk("hs_accept_count", acc, 4);

        // Reset while scanning: no result, outputs cleared, then behaves like warm-up.
        @(negedge clk);
        drive(0, 50, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 50, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        chk("rs_busy_scan", int'(b0.busy), 1);
        rst0 = 1'b0;
        #1;
        chk("rs_y_cleared", int'(b0.Y), 0);
        chk("rs_busy_cleared", int'(b0.busy), 0);
        @(negedge clk);
        rst0 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b0.y_valid) cnt++;
        end
        chk("rs_no_yvalid", cnt, 0);
        chk("rs_y_zero", int'(b0.Y), 0);
        $display("txn reset_mid_scan dut0 Y=%0d", b0.Y);
        send(0, 100, 12, 21, "rs_warmup");

        send(1, 15, 3, 10, "p_15a");
        send(1, 15, 7, 10, "p_15b");
        send(1, 15, 11, 10, "p_15c");
        send(1, 1, 12, 10, "p_1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cs_window_avg.md
Name: cs_window_avg

Overview:
- Parametrised sliding-window "approximate average" engine, successor to the fixed 9-tap computational system block.
- Keeps the last N samples and a running sum, and finds Xappr, the largest window entry that is ≤ floor(sum/N).
- Outputs Y = (sum + N·Xappr) >> SHIFT.
- Uses a valid/ready input handshake, a sequential divider and a sequential scan in place of wide combinational logic. Sits on the sample stream between the input register stage and downstream filtering.

Parameters:
- DW, 8, sample width in bits.
- N, 9, window depth; range 2..64.
- SHIFT, 3, output right-shift; 0 ≤ SHIFT ≤ SW.
- Derived (localparam): SW = DW + clog2(N) is the sum width. YW = SW + 1 − SHIFT is the output width; defaults give SW=12, YW=10.

Ports:
- clk      in   1    rising-edge clock
- reset    in   1    asynchronous, active-low reset
- X        in   DW   input sample
- x_valid  in   1    X is valid this cycle
- x_ready  out  1    block accepts a sample (high only in IDLE)
- flush    in   1    synchronous window clear; honoured only in IDLE
- Y        out  YW   result; holds until the next result
- y_valid  out  1    one-cycle pulse when Y updates
- busy     out  1    high in DIV or SCAN

Behaviour:
- Reset (reset=0, async):
  - all N window entries, sum, Y, quotient and scan registers = 0
  - y_valid=0; FSM=IDLE; x_ready=1 after release
- Window:
  - circular buffer of N entries with write pointer wp (0..N−1), wrapping N−1 → 0
  - entries are zero after reset/flush and count as samples (no fill tracking)
- States:
  - IDLE:
    - x_ready=1.
    - flush=1: clear all entries, sum and wp; stay IDLE. Any x_valid that cycle is discarded. Y is unchanged and there is no y_valid.
    - else x_valid=1: buf[wp]←X; sum←sum − buf[wp] + X (SW bits, never overflows); wp advances; latch the new sum into a divider; go to DIV.
  - DIV: restoring division of sum by N, one quotient bit per cycle, MSB first; exactly SW cycles; result avg = floor(sum/N), SW bits. Then go to SCAN with Xappr=0, index=0.
  - SCAN: one entry per cycle, index 0..N−1 (physical order; order does not affect the result). If buf[idx] ≤ avg and buf[idx] > Xappr, then Xappr←buf[idx]. After index N−1 is examined, on that same edge:
    - Y ← (sum + N·Xappr) >> SHIFT, computed in SW+1 bits and truncated to YW
    - y_valid ← 1 for exactly one cycle; state ← IDLE
- Latency: sample accepted at edge t0 → y_valid high in the cycle after edge t0+SW+N (defaults: 21 edges). x_ready is already high in that y_valid cycle, so back-to-back throughput is 1 sample per SW+N+1 cycles.
- Xappr always exists, because min(window) ≤ avg. Ties are harmless.
- x_valid while not IDLE: ignored, not queued. The sender must hold X/x_valid until x_ready.
- flush while not IDLE: ignored.
- Reset mid-DIV/SCAN: immediate abort. All state cleared, no y_valid, partial result discarded.
- X changing during DIV/SCAN has no effect; the window is only written in IDLE.

Test Plan:
- Warm-up, defaults: reset, send X=100 once. Window {100, 0×8}, sum=100, avg=11, Xappr=0 → Y=12 with y_valid at 21 edges after acceptance; x_ready low for 21 cycles.
- Full window: send 10,20,…,90. The 9th result has sum=450, avg=50, Xappr=50 → Y=112. Then send 100: sum=540, avg=60, Xappr=60 → Y=135, exercising wrap of wp and subtraction of the oldest sample.
- Saturation: nine samples of 255 → sum=2295, avg=255, Xappr=255 → Y=573; no overflow in SW/SW+1 paths.
- Handshake: hold x_valid=1 continuously with changing X. Only values present in IDLE cycles are captured; exactly one y_valid pulse per accepted sample; Y is stable between pulses.
- Flush/reset: after the full-window test, assert flush with x_valid in IDLE → no y_valid, and the next X=90 gives sum=90, avg=10, Xappr=0, Y=11. Pulse reset low during SCAN → y_valid never asserts, Y=0, and the next sample behaves as in warm-up.
- Parametrised: DW=4, N=4, SHIFT=2 (SW=6, YW=5). Samples 15,15,15,1 → sum=46, avg=11, Xappr=1, Y=(46+4)>>2=12; latency SW+N=10 edges.
